// File: rtl/tlm_cred_tracker.sv
`timescale 1ns/1ps
// Multi-channel IOSF primary credit tracker: per (channel, rtype) command and
// data credit counters, loaded by credit returns, gating egress requests.
module tlm_cred_tracker #(
  parameter int NUM_CH       = 2,
  parameter int CMD_CRED_W   = 8,
  parameter int DATA_CRED_W  = 10,
  parameter int CPL_INFINITE = 0,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                tlm_primary_clock,
  input  logic                tlm_primary_reset,
  input  logic                cred_init,
  input  logic                cred_init_done,
  input  logic                cred_ret_put,
  input  logic [CHW-1:0]      cred_ret_chid,
  input  logic [1:0]          cred_ret_rtype,
  input  logic                cred_ret_cmd,
  input  logic                cred_ret_data,
  input  logic                req_valid,
  input  logic [CHW-1:0]      req_chid,
  input  logic [1:0]          req_rtype,
  input  logic                req_cdata,
  input  logic [9:0]          req_dlen,
  output logic                req_ok,
  output logic                req_put,
  output logic [1:0]          cred_state,
  output logic [NUM_CH*3-1:0] cred_avail,
  output logic [1:0]          cred_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam int NRT   = 3;
  localparam int CMP_W = (DATA_CRED_W > 9) ? DATA_CRED_W : 9;
  localparam bit CPL_INF = (CPL_INFINITE != 0);

  state_e state_q, state_d;

  logic [CMD_CRED_W-1:0]  cmd_cnt_q  [NUM_CH][NRT];
  logic [CMD_CRED_W-1:0]  cmd_cnt_d  [NUM_CH][NRT];
  logic [DATA_CRED_W-1:0] data_cnt_q [NUM_CH][NRT];
  logic [DATA_CRED_W-1:0] data_cnt_d [NUM_CH][NRT];
  logic [1:0]             err_q, err_d;

  logic                   st_active;
  logic                   st_live;
  logic [10:0]            req_len;
  logic [8:0]             need_data;
  logic [CMD_CRED_W-1:0]  sel_cmd;
  logic [DATA_CRED_W-1:0] sel_data;
  logic                   req_chid_ok;
  logic                   cpl_skip;
  logic                   cnt_ok;
  logic                   ret_legal;
  logic                   ret_hit_en;
  logic                   ret_illegal;
  logic                   ret_sel;
  logic                   req_sel;
  logic [CMD_CRED_W:0]    cmd_sum;
  logic [DATA_CRED_W:0]   data_sum;
  logic                   ovf_any;

  // ---------------- state machine ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge tlm_primary_clock) begin
    if (tlm_primary_reset) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cred_init) state_d = ST_INIT;
      ST_INIT:   if (!cred_init && cred_init_done) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cred_init) state_d = ST_INIT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cred_state = state_q;
    st_active  = (state_q == ST_ACTIVE);
    st_live    = (state_q == ST_INIT) || (state_q == ST_ACTIVE);
  end

  // ---------------- request gating ----------------
  // Uses registered counts only; a same-cycle return never reaches req_ok.
  always_comb begin
    req_len   = (req_dlen == 10'd0) ? 11'd1024 : {1'b0, req_dlen};
    need_data = req_cdata ? 9'((req_len + 11'd3) >> 2) : 9'd0;
    sel_cmd   = '0;
    sel_data  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int rt = 0; rt < NRT; rt++) begin
        if (int'(req_chid) == ch && int'(req_rtype) == rt) begin
          sel_cmd  = cmd_cnt_q[ch][rt];
          sel_data = data_cnt_q[ch][rt];
        end
      end
    end
    req_chid_ok = (int'(req_chid) < NUM_CH);
    cpl_skip    = CPL_INF && (req_rtype == 2'd2);
    cnt_ok      = (sel_cmd != '0) && (CMP_W'(sel_data) >= CMP_W'(need_data));
    req_ok      = st_active && req_valid && (req_rtype != 2'd3) && req_chid_ok &&
                  (cpl_skip || cnt_ok);
    req_put     = req_valid && req_ok;
  end

  // ---------------- credit returns ----------------
  always_comb begin
    ret_legal   = (cred_ret_rtype != 2'd3) && (int'(cred_ret_chid) < NUM_CH) &&
                  !(CPL_INF && (cred_ret_rtype == 2'd2));
    ret_hit_en  = cred_ret_put && st_live && ret_legal && !cred_init;
    ret_illegal = cred_ret_put && st_live && !ret_legal;
  end

  // Counter next-state: cnt + return - consume, saturating on overflow.
  always_comb begin
    ovf_any  = 1'b0;
    ret_sel  = 1'b0;
    req_sel  = 1'b0;
    cmd_sum  = '0;
    data_sum = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int rt = 0; rt < NRT; rt++) begin
        ret_sel  = ret_hit_en && (int'(cred_ret_chid) == ch) && (int'(cred_ret_rtype) == rt);
        req_sel  = req_put && !cpl_skip && (int'(req_chid) == ch) && (int'(req_rtype) == rt);
        cmd_sum  = {1'b0, cmd_cnt_q[ch][rt]}
                 + (CMD_CRED_W+1)'(ret_sel && cred_ret_cmd)
                 - (CMD_CRED_W+1)'(req_sel);
        data_sum = {1'b0, data_cnt_q[ch][rt]}
                 + (DATA_CRED_W+1)'(ret_sel && cred_ret_data)
                 - (req_sel ? (DATA_CRED_W+1)'(need_data) : {(DATA_CRED_W+1){1'b0}});
        cmd_cnt_d[ch][rt]  = cmd_sum[CMD_CRED_W]   ? '1 : cmd_sum[CMD_CRED_W-1:0];
        data_cnt_d[ch][rt] = data_sum[DATA_CRED_W] ? '1 : data_sum[DATA_CRED_W-1:0];
        if (cmd_sum[CMD_CRED_W] || data_sum[DATA_CRED_W]) ovf_any = 1'b1;
        if (cred_init) begin
          cmd_cnt_d[ch][rt]  = '0;
          data_cnt_d[ch][rt] = '0;
        end
      end
    end
  end

  always_comb err_d = err_q | {ret_illegal, ovf_any};

  // NOTE: the counter arrays are plain flops rather than a RAM, so they are
  // cleared element by element in reset.
  always_ff @(posedge tlm_primary_clock) begin
    if (tlm_primary_reset) begin
      err_q <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        for (int rt = 0; rt < NRT; rt++) begin
          cmd_cnt_q[ch][rt]  <= '0;
          data_cnt_q[ch][rt] <= '0;
        end
      end
    end else begin
      err_q <= err_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        for (int rt = 0; rt < NRT; rt++) begin
          cmd_cnt_q[ch][rt]  <= cmd_cnt_d[ch][rt];
          data_cnt_q[ch][rt] <= data_cnt_d[ch][rt];
        end
      end
    end
  end

  always_comb begin
    cred_avail = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int rt = 0; rt < NRT; rt++) begin
        cred_avail[ch*NRT+rt] = (cmd_cnt_q[ch][rt] != '0);
      end
    end
  end

  assign cred_err = err_q;

endmodule

// File: tb/tb_tlm_cred_tracker.sv
`timescale 1ns/1ps
// Scoreboard bench for tlm_cred_tracker: a finite-completion and an
// infinite-completion instance share stimulus; expectations are queued per step.
module tb_tlm_cred_tracker;
  localparam int NCH = 3;
  localparam int CHW = 2;
  localparam int AW  = NCH * 3;
  localparam int OW  = AW + 6;

  logic clk = 1'b0;
  logic rst;
  logic cred_init, cred_init_done, cred_ret_put, cred_ret_cmd, cred_ret_data;
  logic [CHW-1:0] cred_ret_chid, req_chid;
  logic [1:0] cred_ret_rtype, req_rtype;
  logic req_valid, req_cdata;
  logic [9:0] req_dlen;
  logic ok0, put0, ok1, put1;
  logic [1:0] st0, st1, err0, err1;
  logic [AW-1:0] av0, av1;
  logic [OW-1:0] obs0, obs1, got, want;

  string         name_q[$];
  int            dut_q[$];
  logic [OW-1:0] val_q[$];
  string         nm;
  int            which;

  int total = 0;
  int bad   = 0;
  logic [1:0]    m_state, m_err;
  logic [AW-1:0] m_avail;

  always #5 clk = ~clk;

  assign obs0 = {st0, err0, av0, ok0, put0};
  assign obs1 = {st1, err1, av1, ok1, put1};

  tlm_cred_tracker #(.NUM_CH(NCH), .CPL_INFINITE(0)) u0 (
    .tlm_primary_clock(clk), .tlm_primary_reset(rst),
    .cred_init(cred_init), .cred_init_done(cred_init_done),
    .cred_ret_put(cred_ret_put), .cred_ret_chid(cred_ret_chid),
    .cred_ret_rtype(cred_ret_rtype), .cred_ret_cmd(cred_ret_cmd),
    .cred_ret_data(cred_ret_data), .req_valid(req_valid),
    .req_chid(req_chid), .req_rtype(req_rtype), .req_cdata(req_cdata),
    .req_dlen(req_dlen), .req_ok(ok0), .req_put(put0),
    .cred_state(st0), .cred_avail(av0), .cred_err(err0));

  tlm_cred_tracker #(.NUM_CH(NCH), .CPL_INFINITE(1)) u1 (
    .tlm_primary_clock(clk), .tlm_primary_reset(rst),
    .cred_init(cred_init), .cred_init_done(cred_init_done),
    .cred_ret_put(cred_ret_put), .cred_ret_chid(cred_ret_chid),
    .cred_ret_rtype(cred_ret_rtype), .cred_ret_cmd(cred_ret_cmd),
    .cred_ret_data(cred_ret_data), .req_valid(req_valid),
    .req_chid(req_chid), .req_rtype(req_rtype), .req_cdata(req_cdata),
    .req_dlen(req_dlen), .req_ok(ok1), .req_put(put1),
    .cred_state(st1), .cred_avail(av1), .cred_err(err1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    cred_init = 0; cred_init_done = 0; cred_ret_put = 0; cred_ret_cmd = 0;
    cred_ret_data = 0; cred_ret_chid = '0; cred_ret_rtype = '0;
    req_valid = 0; req_chid = '0; req_rtype = '0; req_cdata = 0; req_dlen = '0;
  endtask

  // Queue the expected observation for one DUT, built from the bench's own model state.
  task automatic push(input string n, input int d, input logic ok);
    name_q.push_back(n);
    dut_q.push_back(d);
    val_q.push_back({m_state, m_err, m_avail, ok, ok & req_valid});
  endtask

  task automatic set_req(input logic v, input logic [CHW-1:0] ch, input logic [1:0] rt,
                         input logic cd, input logic [9:0] dl);
    req_valid = v; req_chid = ch; req_rtype = rt; req_cdata = cd; req_dlen = dl;
  endtask

  task automatic do_ret(input logic [CHW-1:0] ch, input logic [1:0] rt,
                        input logic c, input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      cred_ret_put = 1; cred_ret_chid = ch; cred_ret_rtype = rt;
      cred_ret_cmd = c; cred_ret_data = d;
      tick();
    end
    cred_ret_put = 0; cred_ret_cmd = 0; cred_ret_data = 0;
  endtask

  task automatic pulse_init();
    cred_init = 1; tick(); cred_init = 0; m_state = 2'd1; m_avail = '0;
  endtask

  task automatic pulse_done();
    cred_init_done = 1; tick(); cred_init_done = 0; m_state = 2'd2;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
    m_state = 2'd0; m_err = 2'b00; m_avail = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    cred_init = 1; set_req(1, 0, 0, 0, 0);
    cred_ret_put = 1; cred_ret_cmd = 1;
    tick(); tick();
    m_state = 2'd0; m_err = 2'b00; m_avail = '0;
    push("reset_u0", 0, 0); push("reset_u1", 1, 0);
    #2;
    for (int k = 0; k < 2; k++) begin
      nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
      got = (which == 1) ? obs1 : obs0; total++;
      if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    end
    clr_in(); rst = 0; tick();
  endtask

  task automatic test_fsm();
    cred_init_done = 1; cred_ret_put = 1; cred_ret_cmd = 1; tick(); clr_in();
    push("done_in_idle", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
    pulse_init();
    cred_init = 1; cred_init_done = 1; tick(); clr_in();
    push("init_wins", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
  endtask

  task automatic test_basic();
    do_ret(1, 0, 1, 1, 4);
    do_ret(1, 0, 0, 1, 4);
    m_avail[3] = 1'b1;
    set_req(1, 1, 0, 1, 10'd32);
    push("req_in_init", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick(); req_valid = 0;
    pulse_done();
    set_req(1, 1, 0, 1, 10'd32);
    push("basic_ok", 0, 1);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
    push("basic_repeat", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    set_req(1, 1, 0, 1, 10'd1);
    push("basic_data_zero", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    set_req(1, 1, 0, 0, 10'd1);
    for (int i = 0; i < 3; i++) begin
      push("basic_cmd_left", 0, 1);
      #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
      got = obs0; total++;
      if (got !== want) begin bad++; $display("FAIL %s[%0d]: got %h expected %h", nm, i, got, want); end
      tick();
    end
    m_avail[3] = 1'b0;
    push("basic_cmd_empty", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick(); req_valid = 0;
  endtask

  task automatic test_dlen_max();
    do_ret(0, 0, 1, 1, 2);
    do_ret(0, 0, 0, 1, 253);
    m_avail[0] = 1'b1;
    set_req(1, 0, 0, 1, 10'd0);
    push("dlen0_255", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
    cred_ret_put = 1; cred_ret_chid = 0; cred_ret_rtype = 0; cred_ret_data = 1;
    push("dlen0_nobypass", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick(); cred_ret_put = 0; cred_ret_data = 0;
    push("dlen0_256", 0, 1);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
    set_req(1, 0, 0, 1, 10'd4);
    push("dlen0_drained", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick(); req_valid = 0;
  endtask

  task automatic test_back_to_back_same_ctr();
    do_ret(2, 1, 1, 0, 1);
    m_avail[7] = 1'b1;
    set_req(1, 2, 1, 0, 10'd0);
    cred_ret_put = 1; cred_ret_chid = 2; cred_ret_rtype = 1; cred_ret_cmd = 1;
    push("same_cycle_pre", 0, 1);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick(); cred_ret_put = 0; cred_ret_cmd = 0;
    push("same_cycle_kept", 0, 1);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
    m_avail[7] = 1'b0;
    push("same_cycle_empty", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick(); req_valid = 0;
  endtask

  task automatic test_overflow();
    do_ret(0, 1, 1, 0, 256);
    m_err = 2'b01; m_avail[1] = 1'b1;
    set_req(1, 0, 1, 0, 10'd0);
    push("ovf_flag", 0, 1);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    for (int i = 0; i < 254; i++) tick();
    push("ovf_sat_last", 0, 1);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
    m_avail[1] = 1'b0;
    push("ovf_sat_empty", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick(); req_valid = 0;
    pulse_init();
    push("init_clears", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
    pulse_done();
    set_req(1, 0, 0, 0, 10'd0);
    push("init_zeroed", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick(); req_valid = 0;
    do_reset();
    push("err_reset", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
  endtask

  task automatic test_illegal();
    pulse_init(); pulse_done();
    do_ret(0, 3, 1, 1, 1);
    m_err = 2'b10;
    push("illegal_rtype", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
    do_reset(); pulse_init(); pulse_done();
    do_ret(2'd3, 0, 1, 1, 1);
    m_err = 2'b10;
    push("illegal_chid", 0, 0);
    #2; nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
    got = obs0; total++;
    if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    tick();
  endtask

  task automatic test_cpl_infinite();
    do_reset(); pulse_init(); pulse_done();
    set_req(1, 0, 2, 1, 10'd5);
    push("cpl_inf_ok", 1, 1);
    push("cpl_fin_zero", 0, 0);
    #2;
    for (int k = 0; k < 2; k++) begin
      nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
      got = (which == 1) ? obs1 : obs0; total++;
      if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    end
    tick(); req_valid = 0;
    do_ret(1, 2, 1, 1, 1);
    m_avail[5] = 1'b1;
    push("cpl_ret_fin", 0, 0);
    m_avail = '0; m_err = 2'b10;
    push("cpl_ret_inf", 1, 0);
    #2;
    for (int k = 0; k < 2; k++) begin
      nm = name_q.pop_front(); which = dut_q.pop_front(); want = val_q.pop_front();
      got = (which == 1) ? obs1 : obs0; total++;
      if (got !== want) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, want); end
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_in();
    rst = 1;
    m_state = 2'd0; m_err = 2'b00; m_avail = '0;
    test_reset();
    test_fsm();
    test_basic();
    test_dlen_max();
    test_back_to_back_same_ctr();
    test_overflow();
    test_illegal();
    test_cpl_infinite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
